fwd_regfile_sb: RTL and testbench
=================================

Name: fwd_regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined core, successor to the fixed 32x32, 2-read-port forwarding register file.
- Adds N read ports, configurable width and depth, and a hardwired-zero register 0.
- Adds a per-register pending scoreboard: issue marks a destination busy, writeback clears it.
- Sits between decode (reads and issue) and writeback; hazard/stall logic consumes rd_busy and iss_ready.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers; power of two, at least 2
NREAD, 2, number of read ports, 1..4
AW, $clog2(NREGS), register address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW]
rd_data  out  NREAD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
rd_busy  out  NREAD  port i's register has an outstanding producer
wr_en  in  1  writeback enable
wr_addr  in  AW  writeback register
wr_data  in  XLEN  writeback data
iss_en  in  1  issue request that marks iss_addr pending
iss_addr  in  AW  destination register of the issuing instruction
iss_ready  out  1  issue of iss_addr is accepted this cycle
flush  in  1  clear all pending bits (pipeline squash)
pend_cnt  out  $clog2(NREGS+1)  number of registers currently pending

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers are 0, all pending bits are 0, pend_cnt=0.
  - rd_data reads 0, rd_busy=0, iss_ready=iss_en.
- Register 0:
  - Reads always return 0 with rd_busy=0.
  - Writes to it are discarded; it is never marked pending.
- Write: on the clk rising edge, when wr_en and wr_addr!=0, regs[wr_addr] takes wr_data.
- Read: combinational, zero latency.
  - When wr_en, wr_addr!=0 and wr_addr==rd_addr[i], rd_data[i] is wr_data (write-through bypass).
  - Otherwise rd_data[i] is regs[rd_addr[i]].
- rd_busy[i] = pending[rd_addr[i]] AND NOT (wr_en AND wr_addr==rd_addr[i]) AND rd_addr[i]!=0.
- iss_ready = iss_en AND NOT flush AND (iss_addr==0 OR NOT pending[iss_addr] OR (wr_en AND wr_addr==iss_addr)).
  - Pending stays a single bit per register; a WAW issue stalls.
  - When iss_ready=0 the issue is ignored, and the requester holds iss_en/iss_addr and retries.
- Pending update at the clk edge, highest priority first:
  1. flush: every pending bit clears. A same-cycle writeback still writes data. A same-cycle issue is not accepted.
  2. Accepted issue to register r (r!=0): pending[r] is 1, even if a writeback to r happens in the same cycle (the new producer wins).
  3. wr_en to register r (r!=0) without an accepted issue to r: pending[r] is 0. A writeback to a non-pending register is legal and writes data.
- pend_cnt: registered population count, updated incrementally with +1, -1 or 0 per cycle. Flush sets it to 0.
  - It never exceeds NREGS-1 and never underflows.
  - Assertion: pend_cnt equals the popcount of the pending vector every cycle.
- Reset mid-operation: all state clears immediately; no partial write completes.

Optional Feature:
RF_BYPASS_EN.
- Defined: write-through bypass as described in Behaviour.
- Undefined:
  - rd_data always returns the pre-edge register contents.
  - rd_busy[i] is pending[rd_addr[i]] OR (wr_en AND wr_addr==rd_addr[i] AND rd_addr[i]!=0), so the reader stalls one cycle.
  - iss_ready drops the writeback term.
  - Used for timing-constrained builds.

Decomposition:
- Package rf_pkg holds:
  - Default XLEN/NREGS constants.
  - Function for the pend_cnt width.
  - Helper functions to slice the flattened port vectors.
- One sub-module, rf_scoreboard, owns the pending vector, iss_ready, rd_busy and pend_cnt. Top level owns the storage and read/bypass muxes.

Test Plan:
- Reset release, then read every register on all ports: rd_data=0, rd_busy=0, pend_cnt=0.
- Write 0xDEADBEEF to r5 while port 0 reads r5 in the same cycle: rd_data0=0xDEADBEEF. Without RF_BYPASS_EN: old value and rd_busy0=1. Next cycle: 0xDEADBEEF either way.
- Write 0x1234 to r0 and issue r0: read of r0 returns 0, iss_ready=1, pend_cnt stays 0.
- Issue r7: pend_cnt=1 and rd_busy on r7 reads 1. Second issue of r7: iss_ready=0. Writeback r7 together with a re-issue of r7: iss_ready=1, pending remains 1, pend_cnt=1.
- Issue r3, r4, r9 on consecutive cycles (pend_cnt=3), then flush together with a writeback to r4 (0x55): pend_cnt=0, r4 reads 0x55, and an issue in the flush cycle is rejected.
- Random issue/writeback/flush for 10k cycles against a reference model: pend_cnt equals popcount every cycle. Assert rst_n low mid-sequence: all registers read 0 immediately.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the forwarding register file with scoreboard.
// Optional build macro: RF_BYPASS_EN (write-through bypass on the read ports).
package rf_pkg;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int RF_NREAD_DEF = 2;

    // Width needed to count 0..nregs pending registers.
    function automatic int pend_cnt_w(input int nregs);
        return $clog2(nregs + 1);
    endfunction

    // LSB position of field idx in a flattened vector of w-bit fields.
    function automatic int fld_lsb(input int idx, input int w);
        return idx * w;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register, issue acceptance,
// per-port busy flags and an incrementally maintained pending count.
// Optional build macro: RF_BYPASS_EN (a same-cycle writeback frees the register).
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NREAD = RF_NREAD_DEF,
    localparam int AW   = $clog2(NREGS),
    localparam int CW   = pend_cnt_w(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    input  logic                  flush,
    output logic [NREAD-1:0]      rd_busy,
    output logic                  iss_ready,
    output logic [CW-1:0]         pend_cnt
);

    logic [NREGS-1:0] pending_q, pending_d;
    logic [CW-1:0]    pend_cnt_q, pend_cnt_d;
    logic             wr_live;
    logic             wr_hit;
    logic             wb_frees;
    logic             iss_acc;
    logic             cnt_inc;
    logic             cnt_dec;

    // While reset is held the writeback port has no visible effect.
    assign wr_live = rst_n & wr_en;
    assign wr_hit  = wr_live && (wr_addr != '0);

`ifdef RF_BYPASS_EN
    assign wb_frees = wr_live && (wr_addr == iss_addr);
`else
    assign wb_frees = 1'b0;
`endif

    // Issue acceptance; single pending bit per register means WAW issues stall.
    always_comb begin
        iss_ready = iss_en;
        if (rst_n) begin
            iss_ready = iss_en && !flush &&
                        ((iss_addr == '0) || !pending_q[iss_addr] || wb_frees);
        end
    end

    assign iss_acc = iss_ready && rst_n && (iss_addr != '0);

    // A newly accepted issue to a free register adds one; a writeback that
    // retires a producer (and is not overridden by a new one) removes one.
    assign cnt_inc = iss_acc && !pending_q[iss_addr];
    assign cnt_dec = wr_hit && pending_q[wr_addr] && !(iss_acc && (iss_addr == wr_addr));

    for (genvar i = 0; i < NREAD; i++) begin : g_busy
        logic [AW-1:0] a;
        assign a = rd_addr[fld_lsb(i, AW) +: AW];
`ifdef RF_BYPASS_EN
        assign rd_busy[i] = (a != '0) && pending_q[a] && !(wr_live && (wr_addr == a));
`else
        assign rd_busy[i] = (a != '0) && (pending_q[a] || (wr_live && (wr_addr == a)));
`endif
    end

    // Next pending state: flush beats issue, issue beats writeback.
    always_comb begin
        pending_d  = pending_q;
        pend_cnt_d = pend_cnt_q;
        if (flush) begin
            pending_d  = '0;
            pend_cnt_d = '0;
        end else begin
            if (wr_hit) begin
                pending_d[wr_addr] = 1'b0;
            end
            if (iss_acc) begin
                pending_d[iss_addr] = 1'b1;
            end
            case ({cnt_inc, cnt_dec})
                2'b10:   pend_cnt_d = pend_cnt_q + CW'(1);
                2'b01:   pend_cnt_d = pend_cnt_q - CW'(1);
                default: pend_cnt_d = pend_cnt_q;
            endcase
        end
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

    a_cnt_matches_popcount: assert property (@(posedge clk) disable iff (!rst_n)
        pend_cnt_q == CW'($countones(pending_q)));

endmodule

// File: rtl/fwd_regfile_sb.sv
// Parametrised register file with hardwired-zero r0, NREAD combinational
// read ports and a pending-producer scoreboard for hazard detection.
// Optional build macro: RF_BYPASS_EN (write-through bypass from writeback to reads).
module fwd_regfile_sb
    import rf_pkg::*;
#(
    parameter int XLEN  = RF_XLEN_DEF,
    parameter int NREGS = RF_NREGS_DEF,
    parameter int NREAD = RF_NREAD_DEF,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREAD*AW-1:0]           rd_addr,
    output logic [NREAD*XLEN-1:0]         rd_data,
    output logic [NREAD-1:0]              rd_busy,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [XLEN-1:0]               wr_data,
    input  logic                          iss_en,
    input  logic [AW-1:0]                 iss_addr,
    output logic                          iss_ready,
    input  logic                          flush,
    output logic [pend_cnt_w(NREGS)-1:0]  pend_cnt
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Architectural storage; r0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0]   a;
        logic [XLEN-1:0] q;
        assign a = rd_addr[fld_lsb(i, AW) +: AW];

        // Read mux: r0 reads zero, optionally forwarding the in-flight writeback.
        always_comb begin
            q = (a == '0) ? '0 : regs_q[a];
`ifdef RF_BYPASS_EN
            if (rst_n && wr_en && (wr_addr != '0) && (wr_addr == a)) begin
                q = wr_data;
            end
`endif
        end

        assign rd_data[fld_lsb(i, XLEN) +: XLEN] = q;
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .flush     (flush),
        .rd_busy   (rd_busy),
        .iss_ready (iss_ready),
        .pend_cnt  (pend_cnt)
    );

endmodule

// File: tb/tb_fwd_regfile_sb.sv
// Scoreboard bench for fwd_regfile_sb: a driver issues directed and random
// cycles and queues the expected outputs from a behavioural model; a monitor
// compares on every falling edge.
module tb_fwd_regfile_sb;

    localparam int XL = 32;
    localparam int NR = 16;
    localparam int NP = 3;
    localparam int AW = 4;
    localparam int CW = 5;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP*AW-1:0]  rd_addr = '0;
    logic [NP*XL-1:0]  rd_data;
    logic [NP-1:0]     rd_busy;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [XL-1:0]     wr_data = '0;
    logic              iss_en = 1'b0;
    logic [AW-1:0]     iss_addr = '0;
    logic              iss_ready;
    logic              flush = 1'b0;
    logic [CW-1:0]     pend_cnt;

    fwd_regfile_sb #(.XLEN(XL), .NREGS(NR), .NREAD(NP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .flush     (flush),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NP*XL-1:0] d;
        logic [NP-1:0]    busy;
        logic             rdy;
        logic [CW-1:0]    cnt;
    } exp_t;

    exp_t q_exp[$];
    int   n_chk = 0;
    int   n_err = 0;

    logic [XL-1:0] m_regs [NR];
    bit            m_pend [NR];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    function automatic logic model_ready();
        if (!rst_n) return iss_en;
        return iss_en && !flush &&
               (iss_addr == 0 || !m_pend[iss_addr] || (BYP && wr_en && wr_addr == iss_addr));
    endfunction

    // Apply the register-file rules for one rising edge to the model.
    task automatic model_edge();
        bit acc;
        if (!rst_n) begin
            model_reset();
        end else begin
            acc = model_ready() && (iss_addr != 0);
            if (wr_en && wr_addr != 0) m_regs[wr_addr] = wr_data;
            if (flush) begin
                for (int r = 0; r < NR; r++) m_pend[r] = 1'b0;
            end else begin
                if (wr_en && wr_addr != 0) m_pend[wr_addr] = 1'b0;
                if (acc) m_pend[iss_addr] = 1'b1;
            end
        end
    endtask

    task automatic push_exp();
        exp_t e;
        int   c;
        logic [AW-1:0] a;
        e = '0;
        for (int i = 0; i < NP; i++) begin
            a = rd_addr[i*AW +: AW];
            e.d[i*XL +: XL] = (a == 0) ? '0 : m_regs[a];
            if (BYP) begin
                if (rst_n && wr_en && wr_addr != 0 && wr_addr == a) e.d[i*XL +: XL] = wr_data;
                e.busy[i] = (a != 0) && m_pend[a] && !(wr_en && wr_addr == a);
            end else begin
                e.busy[i] = (a != 0) && (m_pend[a] || (rst_n && wr_en && wr_addr == a));
            end
        end
        e.rdy = model_ready();
        c = 0;
        for (int r = 0; r < NR; r++) c += int'(m_pend[r]);
        e.cnt = CW'(c);
        q_exp.push_back(e);
    endtask

    // One bus cycle: advance the model over the edge, drive new inputs,
    // queue the expectation, then return at the falling edge.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [XL-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia, input logic fl,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic rn);
        @(posedge clk);
        model_edge();
        #1;
        rst_n    = rn;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        flush    = fl;
        rd_addr  = {a2, a1, a0};
        if (!rst_n) model_reset();
        push_exp();
        @(negedge clk);
    endtask

    // Monitor: compare every presented output set against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                for (int i = 0; i < NP; i++) begin
                    chk($sformatf("rd_data%0d", i), rd_data[i*XL +: XL], e.d[i*XL +: XL]);
                    chk($sformatf("rd_busy%0d", i), 32'(rd_busy[i]), 32'(e.busy[i]));
                end
                chk("iss_ready", 32'(iss_ready), 32'(e.rdy));
                chk("pend_cnt", 32'(pend_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [AW-1:0] wa, ia, a0, a1, a2;
        logic          we, ie, fl;
        model_reset();

        // Reset held: issue request passes straight through.
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd5, 1'b0, 4'd1, 4'd2, 4'd3, 1'b0);
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);
        chk("rst_pend_cnt", 32'(pend_cnt), 32'd0);

        // Reset released: sweep every register on all ports.
        for (int r = 0; r < NR; r += NP) begin
            cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'(r), 4'(r + 1), 4'(r + 2), 1'b1);
        end
        chk("init_pend_cnt", 32'(pend_cnt), 32'd0);

        // Writeback to r5 observed by port 0 in the same cycle.
        cyc(1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 4'd5, 4'd5, 4'd0, 1'b1);
        if (BYP) begin
            chk("r5_bypass_data", rd_data[31:0], 32'hDEADBEEF);
            chk("r5_bypass_busy", 32'(rd_busy[0]), 32'd0);
        end else begin
            chk("r5_nobypass_data", rd_data[31:0], 32'h0);
            chk("r5_nobypass_busy", 32'(rd_busy[0]), 32'd1);
        end
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd5, 4'd0, 4'd0, 1'b1);
        chk("r5_next_data", rd_data[31:0], 32'hDEADBEEF);

        // r0 is hardwired zero and never pending.
        cyc(1'b1, 4'd0, 32'h1234, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("r0_data", rd_data[31:0], 32'h0);
        chk("r0_iss_ready", 32'(iss_ready), 32'd1);
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("r0_pend_cnt", 32'(pend_cnt), 32'd0);
        chk("r0_data_after", rd_data[31:0], 32'h0);

        // r7 issue, WAW stall, writeback with re-issue.
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0, 4'd7, 4'd0, 4'd0, 1'b1);
        chk("r7_first_issue", 32'(iss_ready), 32'd1);
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 1'b0, 4'd7, 4'd0, 4'd0, 1'b1);
        chk("r7_pend_cnt", 32'(pend_cnt), 32'd1);
        chk("r7_busy", 32'(rd_busy[0]), 32'd1);
        chk("r7_waw_stall", 32'(iss_ready), 32'd0);
        cyc(1'b1, 4'd7, 32'h77, 1'b1, 4'd7, 1'b0, 4'd7, 4'd0, 4'd0, 1'b1);
        chk("r7_wb_reissue", 32'(iss_ready), BYP ? 32'd1 : 32'd0);
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd7, 4'd0, 4'd0, 1'b1);
        chk("r7_cnt_after", 32'(pend_cnt), BYP ? 32'd1 : 32'd0);
        chk("r7_data_after", rd_data[31:0], 32'h77);
        cyc(1'b1, 4'd7, 32'h78, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd7, 4'd0, 4'd0, 1'b1);
        chk("r7_cleared", 32'(pend_cnt), 32'd0);

        // Three producers, then flush together with a writeback and an issue.
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd3, 1'b0, 4'd3, 4'd4, 4'd9, 1'b1);
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd4, 1'b0, 4'd3, 4'd4, 4'd9, 1'b1);
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 1'b0, 4'd3, 4'd4, 4'd9, 1'b1);
        cyc(1'b1, 4'd4, 32'h55, 1'b1, 4'd2, 1'b1, 4'd3, 4'd4, 4'd9, 1'b1);
        chk("flush_cnt_before", 32'(pend_cnt), 32'd3);
        chk("flush_iss_reject", 32'(iss_ready), 32'd0);
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, 4'd4, 4'd3, 4'd9, 1'b1);
        chk("flush_cnt_after", 32'(pend_cnt), 32'd0);
        chk("flush_r4_data", rd_data[31:0], 32'h55);

        // Random traffic with occasional mid-sequence reset.
        for (int n = 0; n < 10000; n++) begin
            if (n % 2500 == 1200) begin
                a0 = 4'($urandom_range(1, NR - 1));
                cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 1'b0, a0, 4'($urandom), 4'($urandom), 1'b0);
                chk("midrst_data", rd_data[31:0], 32'h0);
                chk("midrst_cnt", 32'(pend_cnt), 32'd0);
            end else begin
                we = 1'($urandom_range(0, 1));
                wa = 4'($urandom_range(0, NR - 1));
                ie = ($urandom_range(0, 9) < 6);
                ia = 4'($urandom_range(0, NR - 1));
                fl = ($urandom_range(0, 39) == 0);
                a0 = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom);
                a1 = ($urandom_range(0, 2) == 0) ? ia : 4'($urandom);
                a2 = 4'($urandom);
                cyc(we, wa, $urandom, ie, ia, fl, a0, a1, a2, 1'b1);
            end
        end

        @(posedge clk);
        chk("queue_drained", 32'(q_exp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
